// File: rtl/button_code_lock.sv
// button_code_lock: combination-lock FSM driven by debounced button pulses.
// Each rising edge of a button line is one press. The press sequence is
// compared against Code, with an inter-press timeout, a timed unlock window
// and a lockout after MaxFails consecutive failed attempts.
//
// Ports:
//   i_clk          system clock, all logic on the rising edge
//   i_reset        synchronous, active-high reset
//   i_buttons      debounced button levels, already synchronous to i_clk
//   o_unlocked     high while the lock is open
//   o_error        one-cycle pulse per failed attempt
//   o_locked_out   high while in lockout
//   o_progress     correct presses accepted in the current attempt
//   o_fail_count   consecutive failures so far
module button_code_lock #(
  parameter int unsigned NumButtons = 4,
  parameter int unsigned CodeLength = 4,
  parameter logic [13:0] Code       = 14'h00E4,
  parameter int unsigned TimeoutMax = 99999999,
  parameter int unsigned UnlockMax  = 249999999,
  parameter int unsigned LockoutMax = 499999999,
  parameter int unsigned MaxFails   = 3,
  parameter int unsigned TimerSize  = 29
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [NumButtons-1:0] i_buttons,
  output logic                  o_unlocked,
  output logic                  o_error,
  output logic                  o_locked_out,
  output logic [2:0]            o_progress,
  output logic [1:0]            o_fail_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_OPEN,
    S_FAIL,
    S_LOCKOUT
  } state_t;

  state_t                 r_state;
  logic [TimerSize-1:0]   r_timer;
  logic [2:0]             r_progress;
  logic [1:0]             r_fail_count;
  logic [NumButtons-1:0]  r_btn_prev;
  logic                   r_unlocked;
  logic                   r_error;
  logic                   r_locked_out;

  logic [NumButtons-1:0]  w_press;
  logic                   w_any_press;
  logic                   w_single;
  logic [1:0]             w_press_idx;
  logic [15:0]            w_code_ext;
  logic [1:0]             w_expected;
  logic                   w_match;
  logic [2:0]             w_progress_inc;
  logic                   w_code_done;
  logic                   w_last_fail;

  // Rising-edge press detection
  assign w_press     = i_buttons & ~r_btn_prev;
  assign w_any_press = |w_press;
  assign w_single    = $onehot(w_press);

  // Index of the pressed button; only meaningful when exactly one bit is set
  always_comb begin
    w_press_idx = 2'd0;
    case (w_press)
      4'b0010: w_press_idx = 2'd1;
      4'b0100: w_press_idx = 2'd2;
      4'b1000: w_press_idx = 2'd3;
      default: w_press_idx = 2'd0;
    endcase
  end

  // Code entry for the current position (padded so every progress value indexes in range)
  assign w_code_ext     = {2'b00, Code};
  assign w_expected     = w_code_ext[{r_progress, 1'b0} +: 2];
  assign w_match        = w_single && (w_press_idx == w_expected);
  assign w_progress_inc = r_progress + 3'd1;
  assign w_code_done    = (w_progress_inc == 3'(CodeLength));
  assign w_last_fail    = ((r_fail_count + 2'd1) == 2'(MaxFails));

  // Lock FSM with registered Moore outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_progress   <= 3'd0;
      r_fail_count <= 2'd0;
      r_btn_prev   <= '1;
      r_unlocked   <= 1'b0;
      r_error      <= 1'b0;
      r_locked_out <= 1'b0;
    end else begin
      r_btn_prev   <= i_buttons;
      // Outputs follow the current state unless a transition below overrides them
      r_error      <= 1'b0;
      r_unlocked   <= (r_state == S_OPEN);
      r_locked_out <= (r_state == S_LOCKOUT);

      case (r_state)
        S_IDLE: begin
          r_timer <= '0;
          if (w_any_press) begin
            if (w_match) begin
              r_progress <= w_progress_inc;
              if (w_code_done) begin
                r_state      <= S_OPEN;
                r_fail_count <= 2'd0;
                r_unlocked   <= 1'b1;
              end else begin
                r_state <= S_ENTRY;
              end
            end else begin
              r_state    <= S_FAIL;
              r_progress <= 3'd0;
              r_error    <= 1'b1;
            end
          end
        end

        S_ENTRY: begin
          if (w_any_press) begin
            // A press always wins over a timeout in the same cycle
            r_timer <= '0;
            if (w_match) begin
              r_progress <= w_progress_inc;
              if (w_code_done) begin
                r_state      <= S_OPEN;
                r_fail_count <= 2'd0;
                r_unlocked   <= 1'b1;
              end
            end else begin
              r_state    <= S_FAIL;
              r_progress <= 3'd0;
              r_error    <= 1'b1;
            end
          end else if (r_timer == TimerSize'(TimeoutMax)) begin
            r_state    <= S_FAIL;
            r_timer    <= '0;
            r_progress <= 3'd0;
            r_error    <= 1'b1;
          end else begin
            r_timer <= r_timer + TimerSize'(1);
          end
        end

        S_FAIL: begin
          r_timer    <= '0;
          r_progress <= 3'd0;
          if (w_last_fail) begin
            r_state      <= S_LOCKOUT;
            r_fail_count <= 2'(MaxFails);
            r_locked_out <= 1'b1;
          end else begin
            r_state      <= S_IDLE;
            r_fail_count <= r_fail_count + 2'd1;
          end
        end

        S_OPEN: begin
          if (r_timer == TimerSize'(UnlockMax)) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_progress <= 3'd0;
            r_unlocked <= 1'b0;
          end else begin
            r_timer <= r_timer + TimerSize'(1);
          end
        end

        S_LOCKOUT: begin
          if (r_timer == TimerSize'(LockoutMax)) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_fail_count <= 2'd0;
            r_locked_out <= 1'b0;
          end else begin
            r_timer <= r_timer + TimerSize'(1);
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_timer    <= '0;
          r_progress <= 3'd0;
        end
      endcase
    end
  end

  assign o_unlocked   = r_unlocked;
  assign o_error      = r_error;
  assign o_locked_out = r_locked_out;
  assign o_progress   = r_progress;
  assign o_fail_count = r_fail_count;

endmodule

// File: tb/tb_button_code_lock.sv
// tb_button_code_lock: directed self-checking bench for button_code_lock
// using short timer limits (timeout 20, unlock 10, lockout 30, code 0,1,2,3).
module tb_button_code_lock;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] buttons;
  logic       unlocked;
  logic       error;
  logic       locked_out;
  logic [2:0] progress;
  logic [1:0] fail_count;

  int errors = 0;
  int checks = 0;

  button_code_lock #(
    .NumButtons (4),
    .CodeLength (4),
    .Code       (14'h00E4),
    .TimeoutMax (20),
    .UnlockMax  (10),
    .LockoutMax (30),
    .MaxFails   (3),
    .TimerSize  (8)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_buttons    (buttons),
    .o_unlocked   (unlocked),
    .o_error      (error),
    .o_locked_out (locked_out),
    .o_progress   (progress),
    .o_fail_count (fail_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One-cycle pulse on a single button
  task automatic press(input int b);
    buttons = 4'(1 << b);
    tick();
    buttons = 4'd0;
  endtask

  task automatic do_reset();
    buttons = 4'd0;
    reset   = 1'b1;
    ticks(2);
    reset   = 1'b0;
    tick();
  endtask

  task automatic enter_code();
    for (int b = 0; b < 4; b++) begin
      press(b);
      if (b != 3) ticks(2);
    end
  endtask

  // Wait until the lock is back in a quiet state, bounded
  task automatic wait_quiet();
    int n;
    n = 0;
    while ((unlocked || locked_out || error) && n < 200) begin
      tick();
      n++;
    end
    check("wait_quiet_bound", int'(n < 200), 1);
  endtask

  initial begin
    int n;
    int err_seen;
    int max_prog;

    reset   = 1'b1;
    buttons = 4'd0;
    ticks(2);
    check("rst_unlocked", unlocked, 0);
    check("rst_error", error, 0);
    check("rst_lockout", locked_out, 0);
    check("rst_progress", progress, 0);
    check("rst_failcnt", fail_count, 0);
    reset = 1'b0;
    tick();

    // Correct entry, 5 cycles apart
    press(0); check("ok_prog1", progress, 1);
    ticks(4);
    press(1); check("ok_prog2", progress, 2);
    ticks(4);
    press(2); check("ok_prog3", progress, 3);
    ticks(4);
    press(3); check("ok_unlocked", unlocked, 1);
    n = 0;
    while (unlocked && n < 100) begin
      tick();
      n++;
    end
    check("ok_open_cycles", n, 11);
    check("ok_idle_prog", progress, 0);
    check("ok_idle_fc", fail_count, 0);

    // Wrong entry 0,2
    tick();
    press(0);
    press(2);
    check("wrong_error", error, 1);
    check("wrong_prog", progress, 0);
    tick();
    check("wrong_error_pulse", error, 0);
    check("wrong_fc", fail_count, 1);
    tick();
    enter_code();
    check("retry_unlocked", unlocked, 1);
    check("retry_fc", fail_count, 0);
    wait_quiet();

    // Timeout: press 0, then nothing; timer reaches 20 one cycle after 20 idle edges
    tick();
    press(0);
    n = 0;
    while (!error && n < 100) begin
      tick();
      n++;
    end
    check("timeout_latency", n, 21);
    tick();
    check("timeout_fc", fail_count, 1);

    // Press arriving exactly when the timer equals the limit is accepted
    do_reset();
    press(0);
    ticks(20);
    check("t20_no_error_yet", error, 0);
    press(1);
    check("t20_prog", progress, 2);
    check("t20_error", error, 0);

    // Lockout after three wrong presses
    do_reset();
    for (int k = 0; k < 3; k++) begin
      press(1);
      check("lk_error", error, 1);
      tick();
      if (k < 2) tick();
    end
    check("lk_active", locked_out, 1);
    check("lk_fc_sat", fail_count, 3);
    n = 0;
    err_seen = 0;
    max_prog = 0;
    while (locked_out && n < 100) begin
      buttons = (n % 2 == 1) ? 4'b0001 : 4'b0000;
      tick();
      n++;
      if (error) err_seen = 1;
      if (int'(progress) > max_prog) max_prog = int'(progress);
    end
    buttons = 4'd0;
    check("lk_cycles", n, 31);
    check("lk_presses_ignored_err", err_seen, 0);
    check("lk_presses_ignored_prog", max_prog, 0);
    check("lk_fc_clear", fail_count, 0);
    tick();

    // Button held 100 cycles: one press, then a single timeout failure
    do_reset();
    buttons  = 4'b0001;
    n        = 0;
    err_seen = 0;
    max_prog = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (error) err_seen++;
      if (int'(progress) > max_prog) max_prog = int'(progress);
    end
    buttons = 4'd0;
    check("hold_one_press", max_prog, 1);
    check("hold_one_fail", err_seen, 1);
    check("hold_fc", fail_count, 1);

    // Two buttons rising together
    do_reset();
    buttons = 4'b0011;
    tick();
    buttons = 4'd0;
    check("dual_error", error, 1);
    check("dual_prog", progress, 0);

    // Button held across reset is not a press until re-pressed
    buttons = 4'b0001;
    reset   = 1'b1;
    ticks(2);
    reset   = 1'b0;
    ticks(3);
    check("held_rst_prog", progress, 0);
    check("held_rst_err", error, 0);
    buttons = 4'd0;
    tick();
    press(0);
    check("held_rst_repress", progress, 1);

    // Reset in ENTRY with progress 2 and a failure on record
    do_reset();
    press(3);
    ticks(2);
    press(0);
    press(1);
    check("mid_prog", progress, 2);
    check("mid_fc", fail_count, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_prog", progress, 0);
    check("mid_rst_fc", fail_count, 0);
    check("mid_rst_unl", unlocked, 0);
    check("mid_rst_err", error, 0);
    check("mid_rst_lk", locked_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
